// File: rtl/cpu_pkg.sv
// Shared opcode map, FSM state encoding and instruction field widths for cpu_core.
package cpu_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
    localparam logic [OPC_W-1:0] OP_STA = 4'h4;
    localparam logic [OPC_W-1:0] OP_LDI = 4'h5;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h6;
    localparam logic [OPC_W-1:0] OP_JC  = 4'h7;
    localparam logic [OPC_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_MEM    = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

endpackage

// File: rtl/cpu_alu_w.sv
// Combinational add/subtract with carry and zero flags; subtract is A + ~B + 1.
// Zero latency, no flow control.
module cpu_alu_w #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_sub,
    output logic [DATA_W-1:0] o_res,
    output logic              o_c,
    output logic              o_z
);

    logic [DATA_W-1:0] w_b;
    logic [DATA_W:0]   w_sum;

    assign w_b   = i_sub ? ~i_b : i_b;
    assign w_sum = {1'b0, i_a} + {1'b0, w_b} + {{DATA_W{1'b0}}, i_sub};
    assign o_res = w_sum[DATA_W-1:0];
    assign o_c   = w_sum[DATA_W];
    assign o_z   = (w_sum[DATA_W-1:0] == '0);

endmodule

// File: rtl/cpu_core.sv
// Accumulator CPU with fetch/decode/mem FSM over a req/ack memory port.
// 2 cycles per register/branch op, 3 per memory op at zero wait; each stalled ack cycle adds one.
module cpu_core
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [DATA_W-1:0] o_out,
    output logic              o_out_valid,
    output logic              o_halted,
    output logic [ADDR_W-1:0] o_pc
);

    state_t            r_state;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_ir;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_out;
    logic              r_out_vld;
    logic              r_c;
    logic              r_z;

    logic [OPC_W-1:0]  w_op;
    logic [ADDR_W-1:0] w_arg;
    logic              w_xfer;
    logic [DATA_W-1:0] w_alu_b;
    logic [DATA_W-1:0] w_res;
    logic              w_c;
    logic              w_z;

    assign w_op  = r_ir[DATA_W-1 -: OPC_W];
    assign w_arg = r_ir[ADDR_W-1:0];

    // Gating with the reset pin lets an in-flight request drop the instant reset asserts.
    assign o_mem_req   = i_reset && (r_state == ST_FETCH || r_state == ST_MEM);
    assign o_mem_we    = i_reset && (r_state == ST_MEM) && (w_op == OP_STA);
    assign o_mem_addr  = (r_state == ST_MEM) ? w_arg : r_pc;
    assign o_mem_wdata = r_a;
    assign w_xfer      = o_mem_req && i_mem_ack;

    assign o_out       = r_out;
    assign o_out_valid = r_out_vld;
    assign o_halted    = (r_state == ST_HALT);
    assign o_pc        = r_pc;

    // B is loaded in the same cycle it is consumed, so the ALU takes the bus value while in MEM.
    assign w_alu_b = (r_state == ST_MEM) ? i_mem_rdata : r_b;

    cpu_alu_w #(.DATA_W(DATA_W)) u_alu (
        .i_a   (r_a),
        .i_b   (w_alu_b),
        .i_sub (w_op == OP_SUB),
        .o_res (w_res),
        .o_c   (w_c),
        .o_z   (w_z)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= ST_FETCH;
            r_a       <= '0;
            r_b       <= '0;
            r_ir      <= '0;
            r_pc      <= '0;
            r_out     <= '0;
            r_out_vld <= 1'b0;
            r_c       <= 1'b0;
            r_z       <= 1'b0;
        end else begin
            r_out_vld <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    if (w_xfer) begin
                        r_ir    <= i_mem_rdata;
                        r_pc    <= r_pc + ADDR_W'(1);
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_state <= ST_FETCH;
                    case (w_op)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: r_state <= ST_MEM;
                        OP_LDI: r_a <= {{(DATA_W-ADDR_W){1'b0}}, w_arg};
                        OP_JMP: r_pc <= w_arg;
                        OP_JC:  if (r_c) r_pc <= w_arg;
                        OP_JZ:  if (r_z) r_pc <= w_arg;
                        OP_OUT: begin
                            r_out     <= r_a;
                            r_out_vld <= 1'b1;
                        end
                        OP_HLT: r_state <= ST_HALT;
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    if (w_xfer) begin
                        r_state <= ST_FETCH;
                        case (w_op)
                            OP_LDA: r_a <= i_mem_rdata;
                            OP_ADD, OP_SUB: begin
                                r_b <= i_mem_rdata;
                                r_a <= w_res;
                                r_c <= w_c;
                                r_z <= w_z;
                            end
                            default: ;
                        endcase
                    end
                end
                default: r_state <= ST_HALT;
            endcase
        end
    end

endmodule

// File: doc/cpu_core.md
# cpu_core

Parametrised single-module successor to the 8-bit bus CPU: an accumulator machine with A and B registers, C/Z flags, PC, instruction register and multi-cycle fetch/decode/execute FSM. The internal ROM/RAM is replaced by an external req/ack memory port with wait states, and data width and address width are generic. It sits between a memory/peripheral fabric and the board LED/output logic, and replaces the distributed register-plus-controller top.

## Interface
- DATA_W, 8, data, A, B, output and instruction word width; must be ≥ ADDR_W+4
- ADDR_W, 4, PC and memory address width; operand field = instr[ADDR_W-1:0]
- i_clk  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- o_mem_req  out  1  memory request, held until accepted
- o_mem_we  out  1  1 = write (STA), 0 = read
- o_mem_addr  out  ADDR_W  request address
- o_mem_wdata  out  DATA_W  write data (A)
- i_mem_ack  in  1  transfer completes on a cycle with req&&ack
- i_mem_rdata  in  DATA_W  read data, valid with ack
- o_out  out  DATA_W  output register
- o_out_valid  out  1  one-cycle pulse when o_out is written
- o_halted  out  1  core is in HALT
- o_pc  out  ADDR_W  current PC (debug)

## Operation
- Opcode = instr[DATA_W-1:DATA_W-4]; arg = instr[ADDR_W-1:0].
- 0 NOP; 1 LDA A←M[arg]; 2 ADD B←M[arg], A←A+B; 3 SUB B←M[arg], A←A−B; 4 STA M[arg]←A; 5 LDI A←zero-extended arg; 6 JMP PC←arg; 7 JC if C; 8 JZ if Z; E OUT o_out←A; F HLT; 9–D execute as NOP.
- ADD: C = carry out of bit DATA_W-1; SUB is computed as A+~B+1, with C = carry out (1 = no borrow). Z = (result==0). Flags change only on ADD/SUB.
- States: FETCH, DECODE, MEM, HALT.
  - FETCH: req=1, we=0, addr=PC. On ack: IR←rdata, PC←PC+1 (mod 2^ADDR_W), then DECODE.
  - DECODE: NOP/LDI/JMP/JC/JZ/OUT/9–D complete here and go to FETCH. HLT goes to HALT. LDA/ADD/SUB/STA go to MEM.
  - MEM: req=1, addr=arg, we=1 only for STA, wdata=A. On ack the operation completes and the FSM goes to FETCH.
  - HALT: absorbing; req=0. Only reset exits.
- Untaken JC/JZ: no effect. A jump to the address just fetched is legal (tight loop).

## Timing
- Reset (asynchronous assert, synchronous release) clears A, B, IR, PC, o_out, C, Z to 0 and sets state to FETCH. All outputs are 0, including o_mem_req, o_out_valid and o_halted.
- First fetch request is in the first cycle after reset release.
- req, we, addr and wdata are registered-state-driven and stable from req rise until the ack cycle. Ack with req=0 is ignored. Ack may be high in the first req cycle (zero wait).
- Zero-wait cycle counts: 2 for NOP/LDI/JMP/Jcc/OUT, 3 for LDA/ADD/SUB/STA. Each wait cycle adds exactly one cycle.
- o_out_valid is high in the cycle after the OUT DECODE edge, for one cycle only.
- o_halted is high from the cycle after the HLT DECODE edge and stays high.
- PC wraps from 2^ADDR_W−1 to 0 with no flag.
- Reset mid-request drops req immediately (asynchronous). The in-flight transfer is abandoned and no state is updated.

## Structure
- Package cpu_pkg holds the opcode localparams (OP_NOP…OP_HLT), the state encoding, and the opcode field width (4).
- Natural sub-module: cpu_alu_w (parameter DATA_W), combinational add/sub returning result, C and Z. Register updates stay in cpu_core.
- The FSM and datapath registers live in one always_ff block with an asynchronous negedge i_reset.

## Test plan
- DATA_W=8, zero-wait memory with M[0..3]={0x55,0x2E,0xE0,0xF0}, M[14]=0x03 → A=0x08, o_out=0x08 with a single pulse, o_halted=1 at cycle 9 after reset release.
- LDA M=0xFF, then ADD M=0x01 → A=0x00, C=1, Z=1. A following JZ 0xA fetches from address 0xA.
- A=0x03, SUB M=0x05 → A=0xFE, C=0, Z=0. A following JC is not taken, and the PC continues sequentially.
- Ack delayed 3 cycles on every request → req, addr and we stay stable, the PC does not advance before ack, and each instruction takes exactly +3 cycles per access. STA writes wdata=A with we=1.
- JMP 0xF with NOP at 15 → the next fetch address is 0x0. Reset asserted during a MEM wait → req=0 in the same cycle, A unchanged at 0, and a fetch from 0 after release.
- DATA_W=16, ADDR_W=8: LDA 0x80 (M=0xFFFF) then ADD 0x81 (M=0x0002) → A=0x0001, C=1, Z=0.
